sync_down_timer: RTL and testbench
==================================

SYNC_DOWN_TIMER -- requirements
Module: sync_down_timer

Interface
REQ-001 Parameter WIDTH, default 16, counter and reload register width in bits.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RESETL  input  1  asynchronous reset, active low.
REQ-004 WR  input  1  reload-register write strobe, one CLK cycle per write.
REQ-005 DIN  input  WIDTH  reload value, sampled when WR=1.
REQ-006 START  input  1  start request.
REQ-007 STOP  input  1  stop request.
REQ-008 MODE  input  1  0 = one-shot, 1 = periodic auto-reload.
REQ-009 CI  input  1  count enable / carry-in from previous stage or prescaler.
REQ-010 IACK  input  1  interrupt acknowledge.
REQ-011 Q  output  WIDTH  current count.
REQ-012 TC  output  1  terminal-count pulse, registered, one cycle wide.
REQ-013 INT  output  1  sticky interrupt flag.
REQ-014 RUN  output  1  high while in COUNT state.
REQ-015 BO  output  1  combinational borrow-out, CI & RUN & (Q==0), for cascading the next stage.

Function
REQ-016 The block SHALL implement states IDLE, COUNT and DONE, with RUN = (state==COUNT).
REQ-017 WR=1 SHALL load RELOAD<=DIN in any state, without altering Q or the state.
REQ-018 START=1 in IDLE or DONE, with STOP=0, SHALL load Q<=RELOAD and enter COUNT on the same edge.
REQ-019 When WR and START are both active on the same edge, Q SHALL load DIN directly (bypass), and RELOAD SHALL also take DIN.
REQ-020 START in COUNT SHALL restart the count: Q<=RELOAD, state stays COUNT, no TC.
REQ-021 In COUNT, each edge with CI=1 and Q!=0 SHALL give Q<=Q-1; with CI=0, Q holds.
REQ-022 In COUNT, an edge with CI=1 and Q==0 SHALL assert TC on the next cycle and set INT.
REQ-023 On that terminal edge, MODE=1 SHALL reload Q<=RELOAD and stay in COUNT; MODE=0 SHALL hold Q=0 and enter DONE.
REQ-024 Period in periodic mode SHALL be RELOAD+1 CI-qualified cycles; RELOAD=0 SHALL give TC on every CI cycle.
REQ-025 STOP=1 SHALL enter IDLE from any state with Q frozen; if STOP and START are simultaneous, STOP SHALL win.
REQ-026 MODE SHALL be sampled only at the terminal edge; changing it mid-count is legal.
REQ-027 IACK=1 SHALL clear INT, except when a terminal edge occurs in the same cycle, in which case set wins and INT stays 1.
REQ-028 TC SHALL be 0 in every cycle not immediately following a terminal edge.
REQ-029 Arithmetic SHALL be unsigned modulo 2^WIDTH; Q SHALL never decrement below 0 (no wrap-around in COUNT).
REQ-030 IDLE and DONE SHALL ignore CI; BO SHALL be 0 outside COUNT.

Reset
REQ-031 RESETL=0 SHALL immediately force Q=0, RELOAD=0, state IDLE, TC=0, INT=0, RUN=0, independent of CLK.
REQ-032 Reset asserted mid-count SHALL abort the count with no TC; after release the block SHALL wait in IDLE for START.
REQ-033 The first active edge after RESETL rises SHALL be honoured normally.

Verification
REQ-034 One-shot: RELOAD=3, MODE=0, START, CI held 1 -> Q goes 3,2,1,0; TC pulses once on the cycle after Q=0 is consumed; state DONE; INT=1; Q stays 0.
REQ-035 Periodic: RELOAD=2, MODE=1, CI=1 continuous -> TC every 3 cycles; Q sequence 2,1,0,2,1,0; RUN stays 1.
REQ-036 CI gating: RELOAD=5, CI toggling 1/0 -> Q decrements only on CI=1 edges; BO=1 only when CI=1 and Q=0.
REQ-037 Simultaneous events: STOP+START -> IDLE with Q frozen; IACK on the terminal edge -> INT=1; WR DIN=7 with START -> Q=7.
REQ-038 Reset mid-count: RELOAD=0x1234, count about 10 cycles, pulse RESETL low asynchronously -> all outputs 0 at once, no TC, IDLE after release.
REQ-039 Edge case: RELOAD=0, MODE=1 -> TC=1 on every cycle with CI=1; RELOAD=2^WIDTH-1 one-shot -> exactly one TC after 2^WIDTH CI cycles.

Source files
------------

// File: rtl/sync_down_timer.sv
// Loadable down-counter with one-shot / periodic auto-reload, terminal-count pulse,
// sticky interrupt and a combinational borrow-out for cascading further stages.
module sync_down_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESETL,
  input  logic             WR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic             CI,
  input  logic             IACK,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             INT,
  output logic             RUN,
  output logic             BO
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             int_q;
  logic [WIDTH-1:0] load_val_s;
  logic             terminal_s;

  // Start value bypasses the reload register when written on the same edge;
  // a terminal edge only exists when neither STOP nor START overrides it.
  always_comb begin
    load_val_s = reload_q;
    terminal_s = 1'b0;
    if (WR) begin
      load_val_s = DIN;
    end else begin
      load_val_s = reload_q;
    end
    if ((state_q == ST_COUNT) && !STOP && !START && CI && (q_q == ZERO_C)) begin
      terminal_s = 1'b1;
    end else begin
      terminal_s = 1'b0;
    end
  end

  // Control FSM, counter, reload register and registered flags.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q  <= ST_IDLE;
      q_q      <= ZERO_C;
      reload_q <= ZERO_C;
      tc_q     <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      if (WR) begin
        reload_q <= DIN;
      end
      tc_q <= terminal_s;
      if (terminal_s) begin
        int_q <= 1'b1;
      end else if (IACK) begin
        int_q <= 1'b0;
      end
      if (STOP) begin
        state_q <= ST_IDLE;
      end else if (START) begin
        q_q     <= load_val_s;
        state_q <= ST_COUNT;
      end else begin
        case (state_q)
          ST_COUNT: begin
            if (CI) begin
              if (q_q == ZERO_C) begin
                // MODE is only looked at here, so changing it mid-count is harmless.
                if (MODE) begin
                  q_q <= reload_q;
                end else begin
                  state_q <= ST_DONE;
                end
              end else begin
                q_q <= q_q - ONE_C;
              end
            end
          end
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign Q   = q_q;
  assign TC  = tc_q;
  assign INT = int_q;
  assign RUN = (state_q == ST_COUNT);
  assign BO  = CI & RUN & (q_q == ZERO_C);

endmodule

// File: tb/tb_sync_down_timer.sv
// Scoreboard bench for sync_down_timer: the driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares.
module tb_sync_down_timer;

  logic        clk;
  logic        resetl;
  logic        wr;
  logic [15:0] din;
  logic        start;
  logic        stop;
  logic        mode;
  logic        ci;
  logic        iack;
  logic [15:0] q;
  logic        tc;
  logic        intr;
  logic        run;
  logic        bo;

  int total;
  int bad;

  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] q;
    logic        tc;
    logic        intr;
    logic        run;
    logic        bo;
  } exp_t;

  exp_t exp_q[$];
  int   tag_n;

  sync_down_timer #(.WIDTH(16)) dut (
    .CLK(clk), .RESETL(resetl), .WR(wr), .DIN(din), .START(start), .STOP(stop),
    .MODE(mode), .CI(ci), .IACK(iack), .Q(q), .TC(tc), .INT(intr), .RUN(run), .BO(bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [15:0] eq, input logic etc,
                         input logic eint, input logic erun, input logic ebo);
    total++;
    if ({q, tc, intr, run, bo} !== {eq, etc, eint, erun, ebo}) begin
      bad++;
      $display("FAIL %s: got q=%h tc=%b int=%b run=%b bo=%b, want q=%h tc=%b int=%b run=%b bo=%b",
               name, q, tc, intr, run, bo, eq, etc, eint, erun, ebo);
    end
  endtask

  // Monitor: one expectation is consumed just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare($sformatf("step%0d", e.tag), e.q, e.tc, e.intr, e.run, e.bo);
    end
  end

  task automatic cyc(input logic w, input logic [15:0] d, input logic s, input logic p,
                     input logic m, input logic c, input logic a,
                     input logic [15:0] eq, input logic etc, input logic eint,
                     input logic erun, input logic ebo);
    exp_t e;
    @(negedge clk);
    wr = w; din = d; start = s; stop = p; mode = m; ci = c; iack = a;
    e.tag = tag_n[15:0]; e.q = eq; e.tc = etc; e.intr = eint; e.run = erun; e.bo = ebo;
    tag_n++;
    exp_q.push_back(e);
  endtask

  initial begin
    total = 0; bad = 0; tag_n = 0;
    resetl = 1'b0; wr = 1'b0; din = 16'h0000; start = 1'b0; stop = 1'b0;
    mode = 1'b0; ci = 1'b0; iack = 1'b0;
    #2;
    compare("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    resetl = 1'b1;

    //   wr   din       st    sp    md    ci    ack    q        tc    int   run   bo
    // one-shot RELOAD=3
    cyc(1'b1, 16'd3,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  16'd3,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd2,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd1,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  16'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    // periodic RELOAD=2, then STOP with IACK
    cyc(1'b1, 16'd2,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b1, 1'b0, 1'b1, 1'b1, 1'b0,  16'd2,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd1,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd0,   1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd2,   1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd1,   1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd0,   1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd2,   1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  16'd2,   1'b0, 1'b0, 1'b0, 1'b0);
    // CI gating, RELOAD=5 one-shot
    cyc(1'b1, 16'd5,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  16'd2,   1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  16'd5,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd4,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  16'd4,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd3,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  16'd3,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd2,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  16'd2,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd1,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  16'd1,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  16'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b0, 1'b1, 1'b0, 1'b0);
    // WR+START bypass, STOP beats START, IDLE ignores CI
    cyc(1'b1, 16'd7,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  16'd7,   1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd6,   1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  16'd6,   1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd6,   1'b0, 1'b0, 1'b0, 1'b0);
    // RELOAD=0 periodic, IACK on terminal edge, START restart at Q=0
    cyc(1'b1, 16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  16'd6,   1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  16'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1,  16'd0,   1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd0,   1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  16'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  16'd0,   1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 16'd4,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  16'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b1, 1'b0, 1'b1, 1'b1, 1'b0,  16'd4,   1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  16'd4,   1'b0, 1'b1, 1'b0, 1'b0);
    // reset mid-count, RELOAD=0x1234
    cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd4,   1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  16'h1234, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234 - 16'(i), 1'b0, 1'b1, 1'b1, 1'b0);
    end
    @(negedge clk);
    #2;
    resetl = 1'b0;
    #1;
    compare("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    compare("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetl = 1'b1;
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  16'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  16'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    // full-range one-shot: exactly one TC after 2^16 CI cycles
    cyc(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 65535; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF - 16'(i), 1'b0, 1'b0, 1'b1,
          (i == 65535) ? 1'b1 : 1'b0);
    end
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  16'd0,   1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
